// File: rtl/music_pkg.sv
// Shared definitions for the tone output stage: envelope state encoding,
// default envelope timing/step constants and the PWM resolution.
package music_pkg;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

  localparam int unsigned ENV_DIV_DEF      = 25000;
  localparam int unsigned ATTACK_STEP_DEF  = 8;
  localparam int unsigned DECAY_STEP_DEF   = 2;
  localparam int unsigned SUSTAIN_LVL_DEF  = 160;
  localparam int unsigned RELEASE_STEP_DEF = 4;

  localparam int unsigned PWM_W = 8;

endpackage

// File: rtl/pwm_dac.sv
// 8-bit PWM stage: free-running frame counter, amplitude latched at the frame
// boundary, tone bit gated by the duty compare.
module pwm_dac
  import music_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic [PWM_W-1:0] amp_next,
  input  logic             tone_q,
  output logic             speaker
);

  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] amp;

  // amp only moves on the last count of a frame so a duty change never
  // produces a runt or stretched pulse inside a frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt <= '0;
      amp     <= '0;
      speaker <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '1) begin
        amp <= amp_next;
      end
      speaker <= tone_q & (pwm_cnt < amp);
    end
  end

endmodule

// File: rtl/tone_envelope_pwm.sv
// Speaker output stage: ADSR envelope on the note gate, scaled by master
// volume, applied to the raw tone through an 8-bit PWM.
module tone_envelope_pwm
  import music_pkg::*;
#(
  parameter int unsigned ENV_DIV      = ENV_DIV_DEF,
  parameter int unsigned ATTACK_STEP  = ATTACK_STEP_DEF,
  parameter int unsigned DECAY_STEP   = DECAY_STEP_DEF,
  parameter int unsigned SUSTAIN_LVL  = SUSTAIN_LVL_DEF,
  parameter int unsigned RELEASE_STEP = RELEASE_STEP_DEF
)(
  input  logic       clk,
  input  logic       resetn,
  input  logic       tone_in,
  input  logic       note_on,
  input  logic [7:0] note_code,
  input  logic [3:0] volume,
  output logic       speaker,
  output logic [7:0] env_level,
  output logic [2:0] env_state,
  output logic       busy
);

  localparam int unsigned PRE_W = $clog2(ENV_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(ENV_DIV - 1);
  localparam logic [8:0] A_STEP = 9'(ATTACK_STEP);
  localparam logic [8:0] D_STEP = 9'(DECAY_STEP);
  localparam logic [8:0] R_STEP = 9'(RELEASE_STEP);
  localparam logic [8:0] SUS9   = 9'(SUSTAIN_LVL);

  logic             tone_q;
  logic             gate_q;
  logic [7:0]       code_q;
  logic [PRE_W-1:0] presc;
  logic             trigger;
  logic             tick;

  env_state_t state_q, state_d;
  logic [7:0] level_q, level_d;
  logic [8:0] sum_up, sum_dec, sum_rel;

  logic [11:0] amp_prod;
  logic [7:0]  amp_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tone_q <= 1'b0;
      gate_q <= 1'b0;
      code_q <= '0;
    end else begin
      tone_q <= tone_in;
      gate_q <= note_on;
      code_q <= note_code;
    end
  end

  assign trigger = note_on & (~gate_q | (note_code != code_q));

  // Restarting the prescaler on trigger puts the first envelope step a full
  // ENV_DIV clocks after the note starts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc <= '0;
    end else if (trigger || presc == PRE_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == PRE_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ENV_IDLE;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  assign sum_up  = {1'b0, level_q} + A_STEP;
  assign sum_dec = {1'b0, level_q} - D_STEP;
  assign sum_rel = {1'b0, level_q} - R_STEP;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (trigger) begin
      state_d = ENV_ATTACK;
    end else if (!gate_q && (state_q == ENV_ATTACK || state_q == ENV_DECAY ||
                             state_q == ENV_SUSTAIN)) begin
      state_d = ENV_RELEASE;
    end else if (tick) begin
      unique case (state_q)
        ENV_ATTACK: begin
          if (sum_up >= 9'd255) begin
            level_d = 8'd255;
            state_d = ENV_DECAY;
          end else begin
            level_d = sum_up[7:0];
          end
        end
        ENV_DECAY: begin
          // bit 8 set means the subtraction borrowed below zero
          if (sum_dec[8] || sum_dec <= SUS9) begin
            level_d = SUS9[7:0];
            state_d = ENV_SUSTAIN;
          end else begin
            level_d = sum_dec[7:0];
          end
        end
        ENV_RELEASE: begin
          if (sum_rel[8] || sum_rel == 9'd0) begin
            level_d = '0;
            state_d = ENV_IDLE;
          end else begin
            level_d = sum_rel[7:0];
          end
        end
        ENV_SUSTAIN: level_d = level_q;
        ENV_IDLE:    level_d = '0;
        default: begin
          level_d = '0;
          state_d = ENV_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    env_state = state_q;
    env_level = level_q;
    busy      = (state_q != ENV_IDLE);
  end

  assign amp_prod = {4'b0, level_q} * {7'b0, {1'b0, volume} + 5'd1};
  assign amp_next = 8'(amp_prod >> 4);

  pwm_dac u_pwm_dac (
    .clk      (clk),
    .resetn   (resetn),
    .amp_next (amp_next),
    .tone_q   (tone_q),
    .speaker  (speaker)
  );

endmodule

// File: tb/tb_tone_envelope_pwm.sv
// Directed bench for tone_envelope_pwm with a short envelope tick (ENV_DIV=4).
module tb_tone_envelope_pwm;

  logic       clk;
  logic       resetn;
  logic       tone_in;
  logic       note_on;
  logic [7:0] note_code;
  logic [3:0] volume;
  logic       speaker;
  logic [7:0] env_level;
  logic [2:0] env_state;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_ATK = 3'd1, S_DEC = 3'd2,
                         S_SUS = 3'd3, S_REL = 3'd4;

  typedef struct {
    logic       note_on;
    logic [7:0] note_code;
    int         n;
    logic [2:0] exp_state;
    logic [7:0] exp_level;
  } vec_t;

  vec_t vecs[$];

  tone_envelope_pwm #(.ENV_DIV(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .tone_in   (tone_in),
    .note_on   (note_on),
    .note_code (note_code),
    .volume    (volume),
    .speaker   (speaker),
    .env_level (env_level),
    .env_state (env_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic on, input logic [7:0] code, input int n,
                     input logic [2:0] st, input logic [7:0] lvl);
    vec_t v;
    v.note_on = on; v.note_code = code; v.n = n; v.exp_state = st; v.exp_level = lvl;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input int i);
    note_on   = vecs[i].note_on;
    note_code = vecs[i].note_code;
    repeat (vecs[i].n) @(posedge clk);
    @(negedge clk);
    chk($sformatf("vec%0d state", i), env_state, vecs[i].exp_state);
    chk($sformatf("vec%0d level", i), env_level, vecs[i].exp_level);
    chk($sformatf("vec%0d busy", i), busy, (vecs[i].exp_state != S_IDLE));
  endtask

  task automatic count_high(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      cnt += speaker;
    end
  endtask

  initial begin
    int  cnt;
    logic prev;
    logic found;

    // attack -> decay -> sustain
    add(0, 8'd0,   2, S_IDLE, 8'd0);
    add(1, 8'd25,  1, S_ATK,  8'd0);
    add(1, 8'd25,  3, S_ATK,  8'd0);
    add(1, 8'd25,  1, S_ATK,  8'd8);
    add(1, 8'd25,  4, S_ATK,  8'd16);
    add(1, 8'd25, 116, S_ATK, 8'd248);
    add(1, 8'd25,  4, S_DEC,  8'd255);
    add(1, 8'd25, 188, S_DEC, 8'd161);
    add(1, 8'd25,  4, S_SUS,  8'd160);
    add(1, 8'd25, 40, S_SUS,  8'd160);
    // retrigger by note change from sustain
    add(1, 8'd27,  1, S_ATK,  8'd160);
    add(1, 8'd27,  3, S_ATK,  8'd160);
    add(1, 8'd27,  1, S_ATK,  8'd168);
    add(1, 8'd27, 40, S_ATK,  8'd248);
    add(1, 8'd27,  4, S_DEC,  8'd255);
    add(1, 8'd27, 188, S_DEC, 8'd161);
    add(1, 8'd27,  4, S_SUS,  8'd160);
    add(1, 8'd27, 40, S_SUS,  8'd160);
    // release from sustain
    add(0, 8'd27,  2, S_REL,  8'd160);
    add(0, 8'd27,  2, S_REL,  8'd156);
    add(0, 8'd27, 152, S_REL, 8'd4);
    add(0, 8'd27,  4, S_IDLE, 8'd0);
    add(0, 8'd27, 20, S_IDLE, 8'd0);
    // new note, interrupted by reset at level 40
    add(1, 8'd30,  1, S_ATK,  8'd0);
    add(1, 8'd30,  3, S_ATK,  8'd0);
    add(1, 8'd30, 20, S_ATK,  8'd40);

    resetn = 1'b0; tone_in = 1'b0; note_on = 1'b0; note_code = '0; volume = 4'd15;
    repeat (3) @(negedge clk);
    chk("reset speaker", speaker, 0);
    chk("reset level", env_level, 0);
    chk("reset state", env_state, S_IDLE);
    chk("reset busy", busy, 0);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i);

    // PWM duty at sustain level 160
    tone_in = 1'b1; volume = 4'd15;
    repeat (600) @(negedge clk);
    count_high(256, cnt);
    chk("duty vol15", cnt, 160);

    prev = speaker; found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      if (!prev && speaker) found = 1'b1;
      prev = speaker;
    end
    chk("frame start found", found, 1);
    if (found) begin
      cnt = 1;
      volume = 4'd7;
      repeat (255) begin
        @(negedge clk);
        cnt += speaker;
      end
      chk("duty frame after mid-frame change", cnt, 160);
      count_high(256, cnt);
      chk("duty vol7 next frame", cnt, 80);
    end

    tone_in = 1'b0;
    repeat (2) @(negedge clk);
    count_high(256, cnt);
    chk("duty tone off", cnt, 0);
    volume = 4'd15;

    for (int i = 10; i < 26; i++) begin
      if (i == 23) tone_in = 1'b1;
      run_vec(i);
    end

    // asynchronous reset mid-attack
    #2 resetn = 1'b0;
    #1;
    chk("async rst speaker", speaker, 0);
    chk("async rst level", env_level, 0);
    chk("async rst state", env_state, S_IDLE);
    chk("async rst busy", busy, 0);
    note_on = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    chk("post rst level", env_level, 0);
    chk("post rst state", env_state, S_IDLE);
    chk("post rst busy", busy, 0);
    count_high(300, cnt);
    chk("post rst speaker", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_envelope_pwm.md
Name: tone_envelope_pwm

Overview:
- Output stage between the square-wave tone generator and the speaker pin.
- Takes the raw tone bit, a note gate and the current note code.
- Applies an attack/decay/sustain/release (ADSR) amplitude envelope and a 4-bit master volume.
- Drives the speaker with the tone bit gated by an 8-bit PWM, so notes fade in and out instead of clicking on and off.

Parameters:
- ENV_DIV, 25000: clocks per envelope tick (1 ms at 25 MHz); must be >= 2.
- ATTACK_STEP, 8: level increment per tick in ATTACK.
- DECAY_STEP, 2: level decrement per tick in DECAY.
- SUSTAIN_LVL, 160: level held in SUSTAIN (0..255).
- RELEASE_STEP, 4: level decrement per tick in RELEASE.

Ports:
- clk  in  1  system clock (25 MHz PLL output)
- resetn  in  1  asynchronous, active-low reset
- tone_in  in  1  raw square wave from the tone generator
- note_on  in  1  gate: high while a note sounds (fullnote != 0 and not in the inter-note gap)
- note_code  in  8  current note code; a change while gated retriggers the envelope
- volume  in  4  master volume (0 = 1/16, 15 = full scale)
- speaker  out  1  PWM-modulated tone to the pin
- env_level  out  8  current envelope level
- env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- busy  out  1  high when env_state != IDLE

Behaviour:
- Reset (async, resetn=0):
  - Outputs: speaker=0, env_level=0, env_state=IDLE, busy=0.
  - Internals: prescaler, pwm_cnt, amp and input registers all 0.
  - Resetn asserted mid-note takes effect immediately, with no drain of the envelope.
- Input registers:
  - tone_in, note_on and note_code are each registered once into tone_q, gate_q and code_q.
  - All logic uses the registered copies.
- trigger (one-clock pulse):
  - Fires on (note_on & ~gate_q), i.e. a rising gate.
  - Also fires on (note_on & gate_q & note_code != code_q), i.e. a note change while gated.
- Prescaler:
  - Counts 0..ENV_DIV-1 and pulses tick when it wraps to 0.
  - trigger forces the prescaler to 0, so the first envelope step lands exactly ENV_DIV clocks after the trigger.
- State machine priority each clock: trigger > gate-off > tick.
- trigger from any state: state becomes ATTACK on the next clock; env_level is kept (retrigger continues from the current level).
- Gate-off: gate_q==0 in ATTACK, DECAY or SUSTAIN moves to RELEASE on the next clock.
- On tick, per state:
  - ATTACK: level = min(255, level + ATTACK_STEP); on reaching 255, go to DECAY.
  - DECAY: level = max(SUSTAIN_LVL, level - DECAY_STEP); on reaching SUSTAIN_LVL, go to SUSTAIN.
  - SUSTAIN: hold.
  - RELEASE: level = max(0, level - RELEASE_STEP); on reaching 0, go to IDLE.
  - IDLE: hold at 0.
- Arithmetic:
  - Saturating, computed 9 bits wide; env_level never wraps.
- Amplitude:
  - amp = (env_level * (volume + 1)) >> 4, 12-bit product, result 8 bits (max 255).
  - amp is loaded only when pwm_cnt == 255, so it changes only at PWM frame boundaries (glitch-free).
- PWM:
  - pwm_cnt is free-running over 8 bits and wraps 255 -> 0.
  - speaker <= tone_q & (pwm_cnt < amp).
  - amp == 0 gives speaker constantly 0; amp == 255 gives a duty of 255/256 while tone_q is high.
- Latency: tone_in to speaker is 2 clocks (input register + output register).

Decomposition:
- Shared package music_pkg holds:
  - the env_state encoding (IDLE..RELEASE);
  - the default ENV_DIV and step constants;
  - PWM width 8.
- One sub-module, pwm_dac:
  - contains pwm_cnt, the frame-aligned amp load and the compare;
  - inputs: clk, resetn, amp_next[7:0], tone_q;
  - output: speaker.

Test Plan (ENV_DIV=4, other parameters default):
- Reset mid-attack: assert resetn=0 while env_level=40 -> speaker, env_level, env_state and busy are all 0 in the same cycle; they stay 0 after release until a new trigger.
- Attack: rising note_on -> ATTACK on the next clock; env_level=8 after 4 clocks; 255 after 32 ticks (saturates, no wrap); then DECAY.
- Decay: continue from 255 -> SUSTAIN after 48 ticks, env_level exactly 160 (clamped, never 159).
- Release: drop note_on in SUSTAIN -> RELEASE next clock; 40 ticks to env_level=0; then IDLE, busy=0.
- PWM duty: SUSTAIN at 160, tone_in=1, volume=15 -> speaker high 160 of each 256-clock frame. volume=7 -> 80/256, with the change applied only at the next frame start. tone_in=0 -> speaker 0.
- Retrigger: note_code 25 -> 27 while gated in SUSTAIN -> ATTACK from 160; reaches 255 after 12 ticks. The prescaler restarts, so the first step lands 4 clocks after the change.
